sram_fifo_ctrl: RTL and testbench

SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

---
 rtl/cnn_pkg.sv | 14 +
 rtl/ob_skid2.sv | 77 +++++++
 rtl/sram_fifo_ctrl.sv | 89 ++++++++
 tb/tb_sram_fifo_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the SRAM-backed FIFO controller.
//   SRAM_RD_LAT : cycles from a read enable (cena=0) to valid data on sram_qa
//   OB_DEPTH    : number of entries in the registered output buffer
//   ob_occ_e    : occupancy of the output buffer
package cnn_pkg;
    localparam int unsigned SRAM_RD_LAT = 1;
    localparam int unsigned OB_DEPTH    = 2;

    typedef enum logic [1:0] {
        OB_EMPTY = 2'd0,
        OB_ONE   = 2'd1,
        OB_TWO   = 2'd2
    } ob_occ_e;
endpackage

// File: rtl/ob_skid2.sv
// Two-entry registered output buffer with a valid/ready output side.
// The upstream side only pushes when it knows there is room, so there is no
// in_ready; a push into a full buffer is ignored.
//   clk, rst    : clock, synchronous active-high reset/flush
//   in_valid    : a word is present on in_data this cycle
//   in_data     : word to store
//   out_valid   : buffer holds at least one word
//   out_ready   : consumer pops the head when out_valid && out_ready
//   out_data    : head register
//   cnt         : number of words held (0..2)
module ob_skid2
    import cnn_pkg::*;
#(
    parameter int WIDTH = 96
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       cnt
);
    ob_occ_e          occ, occ_n;
    logic [WIDTH-1:0] r0, r1, r0_n, r1_n;
    logic             pop;

    always_comb begin
        pop   = (occ != OB_EMPTY) && out_ready;
        occ_n = occ;
        r0_n  = r0;
        r1_n  = r1;
        case ({in_valid, pop})
            2'b10: begin
                if (occ == OB_EMPTY) begin
                    r0_n  = in_data;
                    occ_n = OB_ONE;
                end else if (occ == OB_ONE) begin
                    r1_n  = in_data;
                    occ_n = OB_TWO;
                end
            end
            2'b01: begin
                r0_n  = r1;
                occ_n = (occ == OB_TWO) ? OB_ONE : OB_EMPTY;
            end
            2'b11: begin
                // Arrival and pop on the same edge: the new word goes behind
                // whatever remains after the head leaves.
                if (occ == OB_ONE) begin
                    r0_n = in_data;
                end else begin
                    r0_n = r1;
                    r1_n = in_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= OB_EMPTY;
            r0  <= '0;
            r1  <= '0;
        end else begin
            occ <= occ_n;
            r0  <= r0_n;
            r1  <= r1_n;
        end
    end

    assign out_valid = (occ != OB_EMPTY);
    assign out_data  = r0;
    assign cnt       = occ;
endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller built around an external 1W1R SRAM macro with a registered
// two-entry output buffer, giving registered outputs and 1 word/cycle.
//   clk, rst, clr          : clock, synchronous reset, synchronous flush
//   in_valid/in_ready/in_data     : write side (valid/ready)
//   out_valid/out_ready/out_data  : read side (valid/ready, registered data)
//   count                  : words held in SRAM + in flight + output buffer
//   sram_aa/sram_cena/sram_qa     : SRAM read port (cena active-low)
//   sram_ab/sram_db/sram_cenb     : SRAM write port (cenb active-low)
module sram_fifo_ctrl
    import cnn_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 96
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH)+1:0]   count,
    output logic [$clog2(DEPTH)-1:0]   sram_aa,
    output logic                       sram_cena,
    input  logic [WIDTH-1:0]           sram_qa,
    output logic [$clog2(DEPTH)-1:0]   sram_ab,
    output logic [WIDTH-1:0]           sram_db,
    output logic                       sram_cenb
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;
    localparam logic [AW:0] USED_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0]          wptr, rptr;
    logic [AW:0]            sram_used;
    logic [SRAM_RD_LAT-1:0] rd_pipe;
    logic [3:0]             inflight;
    logic [1:0]             ob_cnt;
    logic                   flush, in_fire, out_fire, rd_issue;

    assign flush    = rst || clr;
    assign in_ready = (sram_used != USED_FULL) && !clr;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign inflight = 4'($countones(rd_pipe));

    // sram_used only counts words whose write edge has passed, so the word
    // being written this cycle can never be the one read. A read is issued
    // only if its data is guaranteed a free output-buffer slot on arrival.
    assign rd_issue = (sram_used != '0) && !flush &&
                      ((4'(ob_cnt) + inflight) < (4'(OB_DEPTH) + 4'(out_fire)));

    assign sram_cenb = !in_fire;
    assign sram_ab   = wptr;
    assign sram_db   = in_data;
    assign sram_cena = !rd_issue;
    assign sram_aa   = rptr;

    always_ff @(posedge clk) begin
        if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            sram_used <= '0;
            rd_pipe   <= '0;
        end else begin
            if (in_fire)  wptr <= wptr + 1'b1;
            if (rd_issue) rptr <= rptr + 1'b1;
            sram_used <= sram_used + (AW+1)'(in_fire) - (AW+1)'(rd_issue);
            rd_pipe   <= SRAM_RD_LAT'({rd_pipe, rd_issue});
        end
    end

    ob_skid2 #(
        .WIDTH (WIDTH)
    ) u_ob (
        .clk       (clk),
        .rst       (flush),
        .in_valid  (rd_pipe[SRAM_RD_LAT-1]),
        .in_data   (sram_qa),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cnt       (ob_cnt)
    );

    assign count = CW'(sram_used) + CW'(inflight) + CW'(ob_cnt);
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural 1W1R SRAM.
module tb_sram_fifo_ctrl;
    localparam int DEPTH = 32;
    localparam int WIDTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst, clr, in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] in_data, out_data;
    logic [AW+1:0]    count;
    logic [AW-1:0]    sram_aa, sram_ab;
    logic             sram_cena, sram_cenb;
    logic [WIDTH-1:0] sram_qa, sram_db;
    logic [WIDTH-1:0] mem [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH-1:0] exp_q[$];
    int tb_used = 0;
    int viol_w = 0, viol_r = 0, port_err = 0;
    int max_cnt = 0;
    logic last_wf, last_rf;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_cenb) mem[sram_ab] <= sram_db;
        if (!sram_cena) sram_qa <= mem[sram_aa];
    end

    sram_fifo_ctrl #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .sram_aa   (sram_aa),
        .sram_cena (sram_cena),
        .sram_qa   (sram_qa),
        .sram_ab   (sram_ab),
        .sram_db   (sram_db),
        .sram_cenb (sram_cenb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock of traffic: drive, observe at negedge, update the model.
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] id, input logic ordy);
        logic wf, rf;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(negedge clk);
        wf = in_valid && in_ready;
        rf = out_valid && out_ready;
        if (wf == sram_cenb) port_err++;
        if (!sram_cenb && !in_ready) viol_w++;
        if (!sram_cena && tb_used == 0) viol_r++;
        if (rf) begin
            if (exp_q.size() == 0) check("pop_unexpected", 32'(out_valid), 32'd0);
            else                   check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        if (int'(count) > max_cnt) max_cnt = int'(count);
        if (wf) exp_q.push_back(id);
        tb_used = tb_used + int'(wf) - int'(!sram_cena);
        last_wf = wf;
        last_rf = rf;
        step();
        if (rst || clr) begin
            exp_q.delete();
            tb_used = 0;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) cycle(1'b0, '0, 1'b1);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_count0"}, 32'(count), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wr, npop, gaps, acc;
        logic first;
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_cena", 32'(sram_cena), 32'd1);
        check("rst_cenb", 32'(sram_cenb), 32'd1);

        // Single word latency
        in_valid = 1'b1; in_data = 16'h1234;
        @(negedge clk);
        check("w1_cenb", 32'(sram_cenb), 32'd0);
        check("w1_ab", 32'(sram_ab), 32'd0);
        check("w1_db", 32'(sram_db), 32'h1234);
        check("w1_cena_idle", 32'(sram_cena), 32'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("r1_cena", 32'(sram_cena), 32'd0);
        check("r1_aa", 32'(sram_aa), 32'd0);
        check("r1_count", 32'(count), 32'd1);
        check("r1_out_valid", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        check("inflight_out_valid", 32'(out_valid), 32'd0);
        check("inflight_count", 32'(count), 32'd1);
        step();
        @(negedge clk);
        check("o1_out_valid", 32'(out_valid), 32'd1);
        check("o1_out_data", 32'(out_data), 32'h1234);
        check("o1_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        check("pop1_count", 32'(count), 32'd0);
        check("pop1_out_valid", 32'(out_valid), 32'd0);
        step();

        // Streaming 0..99
        wr = 0; npop = 0; gaps = 0; first = 1'b0; max_cnt = 0;
        for (int c = 0; c < 400 && npop < 100; c++) begin
            cycle(wr < 100, WIDTH'(wr), 1'b1);
            if (last_wf) wr++;
            if (last_rf) begin
                npop++;
                first = 1'b1;
            end else if (first) gaps++;
        end
        check("stream_npop", 32'(npop), 32'd100);
        check("stream_gaps", 32'(gaps), 32'd0);
        check("stream_maxcnt_le3", 32'(max_cnt <= 3), 32'd1);
        drain("stream");

        // Fill with out_ready low
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, WIDTH'(acc), 1'b0);
            if (last_wf) acc++;
        end
        in_valid = 1'b0;
        check("fill_accepted", 32'(acc), 32'd34);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        check("fill_count", 32'(count), 32'd34);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            cycle(1'b0, '0, 1'b1);
            if (i == 0) check("fill_ready_after_rd", 32'(in_ready), 32'd1);
        end
        drain("fill");

        // Wrap: three rounds of 30 writes then 30 reads
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 30; i++) cycle(1'b1, WIDTH'(16'h0100 * (r + 1) + i), 1'b0);
            check("wrap_count", 32'(count), 32'd30);
            drain("wrap");
        end

        // Random backpressure
        for (int c = 0; c < 2000; c++)
            cycle($urandom_range(0, 3) != 0, WIDTH'($urandom), $urandom_range(0, 2) != 0);
        drain("rand");
        check("no_write_when_full", 32'(viol_w), 32'd0);
        check("no_read_when_empty", 32'(viol_r), 32'd0);
        check("write_port_consistent", 32'(port_err), 32'd0);

        // clr during an in-flight read
        cycle(1'b1, 16'hC000, 1'b0);
        cycle(1'b1, 16'hC001, 1'b0);
        cycle(1'b1, 16'hC002, 1'b0);
        clr = 1'b1; in_valid = 1'b1; in_data = 16'hC0FF;
        @(negedge clk);
        check("clr_in_ready", 32'(in_ready), 32'd0);
        check("clr_cenb", 32'(sram_cenb), 32'd1);
        step();
        clr = 1'b0; in_valid = 1'b0;
        exp_q.delete(); tb_used = 0;
        check("clr_count", 32'(count), 32'd0);
        check("clr_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b1, WIDTH'(16'hD000 + i), 1'b1);
        drain("clr_fresh");

        // rst during an in-flight read
        cycle(1'b1, 16'hE000, 1'b0);
        cycle(1'b1, 16'hE001, 1'b0);
        cycle(1'b1, 16'hE002, 1'b0);
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete(); tb_used = 0;
        check("rst2_count", 32'(count), 32'd0);
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_out_data", 32'(out_data), 32'd0);
        check("rst2_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(16'hF000 + i), 1'b0);
        drain("rst_fresh");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
